branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 101 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
//==============================================================================
// Module      : branch_predictor
// Description : Bimodal 2-bit saturating-counter branch predictor with F->D->E
//               prediction tracking. Define BRANCH_PREDICTOR_GSHARE_EN to hash
//               the fetch index with a global history register (gshare).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_predictor #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pcF,
    input  logic            stall,
    input  logic            flush,
    input  logic            branchE,
    input  logic            takenBranchE,
    output logic            predictionF,
    output logic            predictionE
);

    localparam int c_ENTRIES = 2 ** IDX_W;

    logic [1:0]       r_pht [c_ENTRIES];
    logic [IDX_W-1:0] w_pcIdx;
    logic [IDX_W-1:0] w_idxF;
    logic [IDX_W-1:0] r_idxD;
    logic [IDX_W-1:0] r_idxE;
    logic             r_predD;
    logic             r_vldD;
    logic             r_predE;
    logic             r_vldE;
    logic             w_update;
    logic             w_unusedPc;

    assign w_pcIdx    = pcF[IDX_W+1:2];
    assign w_unusedPc = ^{pcF[PC_W-1:IDX_W+2], pcF[1:0]};
    assign w_update   = branchE & r_vldE;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // History advances only at resolution, never speculatively at fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ghr <= '0;
        end else if (w_update) begin
            r_ghr <= {r_ghr[IDX_W-2:0], takenBranchE};
        end
    end

    assign w_idxF = w_pcIdx ^ r_ghr;
`else
    assign w_idxF = w_pcIdx;
`endif

    // No bypass: a same-cycle update to this entry shows up next cycle.
    assign predictionF = r_pht[w_idxF][1];
    assign predictionE = r_predE & r_vldE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idxD  <= '0;
            r_predD <= 1'b0;
            r_vldD  <= 1'b0;
            r_idxE  <= '0;
            r_predE <= 1'b0;
            r_vldE  <= 1'b0;
        end else begin
            if (!stall) begin
                r_idxD  <= w_idxF;
                r_predD <= predictionF;
                r_idxE  <= r_idxD;
                r_predE <= r_predD;
            end
            // Flush kills both stages; a stall alone inserts a bubble into EX.
            r_vldD <= flush ? 1'b0 : (stall ? r_vldD : 1'b1);
            r_vldE <= flush ? 1'b0 : (stall ? 1'b0 : r_vldD);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_pht[i] <= 2'b01;
            end
        end else if (w_update) begin
            if (takenBranchE && (r_pht[r_idxE] != 2'b11)) begin
                r_pht[r_idxE] <= r_pht[r_idxE] + 2'd1;
            end else if (!takenBranchE && (r_pht[r_idxE] != 2'b00)) begin
                r_pht[r_idxE] <= r_pht[r_idxE] - 2'd1;
            end
        end
    end

endmodule

`default_nettype wire
